leb128_stream_dec: RTL

Byte-serial, parametrised LEB128 decoder. Accepts one encoded byte per cycle on a valid/ready stream. Emits one registered word per completed value, with byte count and error flag. Sits behind byte-oriented ingress logic and supersedes fixed-width, all-bytes-at-once unpacking for variable-length streams. Optional signed (SLEB128) decode.

---
 rtl/leb128_pkg.sv | 21 ++
 rtl/leb128_finalize.sv | 54 +++++
 rtl/leb128_stream_dec.sv | 113 +++++++++++
 3 files changed

// File: rtl/leb128_pkg.sv
// Shared sizing helpers and FSM state type for the LEB128 stream decoder.
package leb128_pkg;

   // Maximum encoded bytes for a W-bit value.
   function automatic int unsigned maxb(input int unsigned w);
      return (w + 6) / 7;
   endfunction

   // Width of the byte-count field (holds 1..maxb).
   function automatic int unsigned lenw(input int unsigned w);
      return $clog2(maxb(w) + 1);
   endfunction

   // Width able to hold any chunk bit position 0..7*maxb.
   function automatic int unsigned shw(input int unsigned w);
      return $clog2(7 * maxb(w) + 1);
   endfunction

   typedef enum logic {ACC, SKIP} state_t;

endpackage

// File: rtl/leb128_finalize.sv
// Merges the terminating chunk into the accumulator and flags overflow.
// Signed (SLEB128) extension and overflow rule only with LEB128_SIGNED_EN.
module leb128_finalize
   import leb128_pkg::*;
#(
   parameter  int unsigned W   = 64,
   localparam int unsigned LW  = lenw(W),
   localparam int unsigned SHW = shw(W)
) (
   input  logic [W-1:0]  i_acc,
   input  logic [6:0]    i_chunk,
   input  logic [LW-1:0] i_n,
`ifdef LEB128_SIGNED_EN
   input  logic          i_sgn,
`endif
   output logic [W-1:0]  o_value,
   output logic          o_ovf
);

   logic [SHW-1:0] w_sh;
   logic [W+6:0]   w_wide;

   // Seven spare bits above W catch chunk bits that fall off the word.
   assign w_sh   = SHW'(i_n) * SHW'(7);
   assign w_wide = {7'd0, i_acc} | ((W+7)'(i_chunk) << w_sh);

`ifdef LEB128_SIGNED_EN
   logic [SHW-1:0] w_top;
   logic [W-1:0]   w_ext;
   logic [6:0]     w_hmask;

   assign w_top   = w_sh + SHW'(6);
   assign w_ext   = {W{1'b1}} << (w_top + SHW'(1));
   assign w_hmask = ~(7'h7F << (w_top - SHW'(W) + SHW'(1)));

   always_comb begin
      o_value = w_wide[W-1:0];
      o_ovf   = |w_wide[W+6:W];
      if (i_sgn) begin
         if (w_top < SHW'(W)) begin
            if (w_wide[w_top]) o_value = w_wide[W-1:0] | w_ext;
            o_ovf = 1'b0;
         end else begin
            // Only bits actually carried by the chunk must match the sign.
            o_ovf = |((w_wide[W+6:W] ^ {7{w_wide[W-1]}}) & w_hmask);
         end
      end
   end
`else
   assign o_value = w_wide[W-1:0];
   assign o_ovf   = |w_wide[W+6:W];
`endif

endmodule

// File: rtl/leb128_stream_dec.sv
// Byte-serial LEB128 decoder: valid/ready byte in, registered word out.
// Define LEB128_SIGNED_EN to add the i_in_signed port and SLEB128 decode.
module leb128_stream_dec
   import leb128_pkg::*;
#(
   parameter  int unsigned W    = 64,
   localparam int unsigned MAXB = maxb(W),
   localparam int unsigned LW   = lenw(W),
   localparam int unsigned SHW  = shw(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    i_in_data,
   input  logic          i_in_valid,
   output logic          o_in_ready,
`ifdef LEB128_SIGNED_EN
   input  logic          i_in_signed,
`endif
   output logic [W-1:0]  o_out_data,
   output logic [LW-1:0] o_out_len,
   output logic          o_out_err,
   output logic          o_out_valid,
   input  logic          i_out_ready
);

   state_t         r_state;
   logic [W-1:0]   r_acc;
   logic [LW-1:0]  r_n;
   logic           w_fire;
   logic           w_cont;
   logic           w_lastb;
   logic [SHW-1:0] w_sh;
   logic [W-1:0]   w_acc_nxt;
   logic [W-1:0]   w_value;
   logic           w_ovf;

   assign o_in_ready = !o_out_valid || i_out_ready;
   assign w_fire     = i_in_valid && o_in_ready;
   assign w_cont     = i_in_data[7];
   assign w_lastb    = (r_n == LW'(MAXB - 1));
   assign w_sh       = SHW'(r_n) * SHW'(7);
   assign w_acc_nxt  = r_acc | (W'(i_in_data[6:0]) << w_sh);

`ifdef LEB128_SIGNED_EN
   logic r_sgn;
   logic w_sgn;

   // Signedness is taken from the first byte and held for the whole value.
   assign w_sgn = (r_n == '0) ? i_in_signed : r_sgn;
`endif

   leb128_finalize #(.W(W)) u_fin (
      .i_acc   (r_acc),
      .i_chunk (i_in_data[6:0]),
      .i_n     (r_n),
`ifdef LEB128_SIGNED_EN
      .i_sgn   (w_sgn),
`endif
      .o_value (w_value),
      .o_ovf   (w_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ACC;
         r_acc       <= '0;
         r_n         <= '0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_out_len   <= '0;
         o_out_err   <= 1'b0;
`ifdef LEB128_SIGNED_EN
         r_sgn       <= 1'b0;
`endif
      end else begin
         // A load below overrides this clear when both happen together.
         if (o_out_valid && i_out_ready) o_out_valid <= 1'b0;
         if (w_fire) begin
            case (r_state)
               ACC: begin
`ifdef LEB128_SIGNED_EN
                  r_sgn <= w_sgn;
`endif
                  if (!w_cont) begin
                     o_out_valid <= 1'b1;
                     o_out_data  <= w_value;
                     o_out_len   <= r_n + LW'(1);
                     o_out_err   <= w_ovf;
                     r_acc       <= '0;
                     r_n         <= '0;
                  end else if (w_lastb) begin
                     o_out_valid <= 1'b1;
                     o_out_data  <= w_acc_nxt;
                     o_out_len   <= LW'(MAXB);
                     o_out_err   <= 1'b1;
                     r_acc       <= '0;
                     r_n         <= '0;
                     r_state     <= SKIP;
                  end else begin
                     r_acc <= w_acc_nxt;
                     r_n   <= r_n + LW'(1);
                  end
               end
               SKIP: begin
                  if (!w_cont) r_state <= ACC;
               end
               default: r_state <= ACC;
            endcase
         end
      end
   end

endmodule
